// File: rtl/fft_byte_serializer.sv
// fft_byte_serializer
// Buffers WORD_W-bit result words from the FFT datapath in a small FIFO and
// streams them out one byte per valid/ready handshake, LSB byte first.
// Optional feature: define SER_CHECKSUM_EN to append one XOR checksum byte
// to every word (frame length WORD_W/8 + 1 instead of WORD_W/8).
module fft_byte_serializer #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     in_valid,
    input  logic [WORD_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [7:0]               out_byte,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int NBYTES = WORD_W / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

`ifdef SER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
    typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [WORD_W-1:0] head;

    state_t            state;
    logic [WORD_W-1:0] sreg;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     next_idx;

    logic hs;
    logic last_byte;
    logic frame_end;
    logic push;
    logic pop;

`ifdef SER_CHECKSUM_EN
    function automatic logic [7:0] byte_xor(input logic [WORD_W-1:0] w);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < NBYTES; i++) x ^= w[8*i +: 8];
        return x;
    endfunction
`endif

    // in_ready depends only on the registered count, so a same-edge pop
    // never opens the input while full.
    assign in_ready   = (count != CW'(DEPTH));
    assign fifo_count = count;
    assign busy       = (state != IDLE);
    assign head       = mem[rd_ptr];

    assign hs        = ena & out_valid & out_ready;
    assign last_byte = (idx == IW'(NBYTES - 1));
    assign next_idx  = idx + 1'b1;
`ifdef SER_CHECKSUM_EN
    assign frame_end = hs & (state == CSUM);
`else
    assign frame_end = hs & (state == SEND) & last_byte;
`endif
    // A pop refills sreg either from IDLE or on the final byte of a frame,
    // which gives back-to-back words with no bubble.
    assign pop  = ena & (count != '0) & ((state == IDLE) | frame_end);
    assign push = ena & in_valid & in_ready;

    // FIFO storage: written on push only.
    // NOTE: the data array carries no reset; validity is tracked by count and
    // the pointers, so clearing the storage would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Serializer FSM with registered out_valid/out_byte; frozen while ena=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_byte  <= '0;
        end else if (ena) begin
            if (pop) begin
                sreg      <= head;
                idx       <= '0;
                out_byte  <= head[7:0];
                out_valid <= 1'b1;
                state     <= SEND;
            end else if (frame_end) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_byte  <= '0;
            end else if (hs && state == SEND) begin
`ifdef SER_CHECKSUM_EN
                if (last_byte) begin
                    state    <= CSUM;
                    out_byte <= byte_xor(sreg);
                end else
`endif
                begin
                    idx      <= next_idx;
                    out_byte <= 8'(sreg >> {next_idx, 3'b000});
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_byte_serializer.sv
// Self-checking bench for fft_byte_serializer. The reference model turns each
// accepted word into its expected byte frame; a negedge monitor records every
// completed output handshake and flags any change of out_byte during a stall.
module tb_fft_byte_serializer;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int NB     = WORD_W / 8;
`ifdef SER_CHECKSUM_EN
    localparam int FL = NB + 1;
`else
    localparam int FL = NB;
`endif

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [7:0]        out_byte;
    logic              out_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    int stab_err = 0;

    logic [7:0]        exp_q[$];
    logic [7:0]        got_q[$];
    logic [WORD_W-1:0] tx_q[$];

    fft_byte_serializer #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready),
        .fifo_count(fifo_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a word becomes its bytes LSB first, plus XOR byte.
    function automatic void model_push(input logic [WORD_W-1:0] w);
        logic [7:0] x;
        logic [7:0] b;
        x = '0;
        for (int i = 0; i < NB; i++) begin
            b = w[8*i +: 8];
            exp_q.push_back(b);
            x ^= b;
        end
`ifdef SER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    // Monitor: inputs settle 1ns after posedge, so at negedge the upcoming
    // edge's handshake is already known.
    logic       stall_prev;
    logic [7:0] byte_prev;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev && out_valid && out_byte !== byte_prev)
                stab_err <= stab_err + 1;
            if (ena && out_valid && out_ready) got_q.push_back(out_byte);
            stall_prev <= out_valid && !(ena && out_ready);
            byte_prev  <= out_byte;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues;
        exp_q.delete();
        got_q.delete();
        tx_q.delete();
    endtask

    // Feeds tx_q into the DUT and drives out_ready per mode
    // (0: always, 1: pattern 1,0,0, other: random) until all bytes arrive.
    task automatic run_stream(input int mode, input int max_cyc, output bit to);
        int c;
        bit acc;
        c  = 0;
        to = 1'b0;
        while (tx_q.size() > 0 || got_q.size() < exp_q.size()) begin
            if (c >= max_cyc) begin
                to = 1'b1;
                break;
            end
            in_valid = (tx_q.size() > 0);
            in_data  = in_valid ? tx_q[0] : '0;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            acc = in_valid && in_ready && ena;
            tick;
            if (acc) model_push(tx_q.pop_front());
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    // Pushes n words with out_ready low; returns how many were accepted.
    task automatic fill(input int n, output int acc_n);
        logic [WORD_W-1:0] w;
        bit a;
        acc_n     = 0;
        out_ready = 1'b0;
        w         = $urandom;
        for (int c = 0; c < 12; c++) begin
            in_valid = (acc_n < n);
            in_data  = w;
            a = in_valid && in_ready;
            tick;
            if (a) begin
                model_push(w);
                acc_n++;
                w = $urandom;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (fifo_count !== '0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (out_byte !== 8'h00) begin n_fail++; $display("FAIL reset_out_byte: got %h want 00", out_byte); end
        tick;
        rst_n = 1'b1;
        // Get into SEND with a second word queued, then reset mid-cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = $urandom;
        tick;
        in_data   = $urandom;
        tick;
        in_valid  = 1'b0;
        tick;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_send: got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_in_ready: got %b want 1", in_ready); end
        n_checks++; if (fifo_count !== '0) begin n_fail++; $display("FAIL async_fifo_count: got %0d want 0", fifo_count); end
        tick;
        rst_n = 1'b1;
        clear_queues();
        out_ready = 1'b1;
        repeat (6) tick;
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL stale_bytes: got %0d bytes want 0", got_q.size()); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stale_out_valid: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_single;
        clear_queues();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h44332211;
        model_push(in_data);
        tick;
        in_valid = 1'b0;
        n_checks++; if (fifo_count !== 1) begin n_fail++; $display("FAIL single_count_after_push: got %0d want 1", fifo_count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
        tick;
        n_checks++; if (fifo_count !== 0) begin n_fail++; $display("FAIL single_count_after_pop: got %0d want 0", fifo_count); end
        for (int i = 0; i < FL; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++; if (out_byte !== exp_q[i]) begin n_fail++; $display("FAIL single_byte[%0d]: got %h want %h", i, out_byte, exp_q[i]); end
            tick;
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", busy); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        bit to;
        for (int pass = 0; pass < 2; pass++) begin
            clear_queues();
            stab_err = 0;
            for (int k = 0; k < 3 + 3 * pass; k++) tx_q.push_back($urandom);
            run_stream(pass == 0 ? 1 : 2, 400, to);
            n_checks++; if (to) begin n_fail++; $display("FAIL bp_timeout[%0d]: got %0d bytes want %0d", pass, got_q.size(), exp_q.size()); end
            n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_len[%0d]: got %0d want %0d", pass, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte[%0d][%0d]: got %h want %h", pass, i, got_q[i], exp_q[i]); end
            end
            n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_stable[%0d]: got %0d changes want 0", pass, stab_err); end
        end
    endtask

    task automatic test_full;
        int acc_n;
        clear_queues();
        fill(5, acc_n);
        n_checks++; if (acc_n != 5) begin n_fail++; $display("FAIL full_accepted: got %0d want 5", acc_n); end
        n_checks++; if (fifo_count !== DEPTH) begin n_fail++; $display("FAIL full_count: got %0d want %0d", fifo_count, DEPTH); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid: got %b want 1", out_valid); end
        in_valid = 1'b1;
        in_data  = $urandom;
        for (int c = 0; c < 3; c++) begin
            tick;
            n_checks++; if (fifo_count !== DEPTH) begin n_fail++; $display("FAIL full_reject[%0d]: got %0d want %0d", c, fifo_count, DEPTH); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5 * FL) tick;
        out_ready = 1'b0;
        n_checks++; if (got_q.size() != 5 * FL) begin n_fail++; $display("FAIL full_gapless: got %0d bytes want %0d", got_q.size(), 5 * FL); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", out_valid); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_simultaneous;
        int acc_n;
        bit to;
        logic [WORD_W-1:0] w6;
        clear_queues();
        fill(5, acc_n);
        n_checks++; if (fifo_count !== DEPTH) begin n_fail++; $display("FAIL simul_full: got %0d want %0d", fifo_count, DEPTH); end
        out_ready = 1'b1;
        repeat (FL - 1) tick;
        w6       = $urandom;
        in_valid = 1'b1;
        in_data  = w6;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL simul_ready_at_pop: got %b want 0", in_ready); end
        tick;
        n_checks++; if (fifo_count !== DEPTH - 1) begin n_fail++; $display("FAIL simul_count_pop: got %0d want %0d", fifo_count, DEPTH - 1); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready_after: got %b want 1", in_ready); end
        out_ready = 1'b0;
        tick;
        model_push(w6);
        in_valid = 1'b0;
        n_checks++; if (fifo_count !== DEPTH) begin n_fail++; $display("FAIL simul_count_push: got %0d want %0d", fifo_count, DEPTH); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL simul_ready_full: got %b want 0", in_ready); end
        run_stream(0, 200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL simul_timeout: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL simul_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ena;
        logic [7:0] b;
        logic [$clog2(DEPTH):0] fc;
        int nr;
        bit to;
        clear_queues();
        stab_err  = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = $urandom;
        model_push(in_data);
        tick;
        in_data   = $urandom;
        model_push(in_data);
        tick;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        tick;
        b  = out_byte;
        fc = fifo_count;
        nr = got_q.size();
        n_checks++; if (b !== exp_q[2]) begin n_fail++; $display("FAIL ena_pre_byte: got %h want %h", b, exp_q[2]); end
        ena      = 1'b0;
        in_valid = 1'b1;
        in_data  = $urandom;
        for (int c = 0; c < 3; c++) begin
            tick;
            n_checks++; if (out_byte !== b) begin n_fail++; $display("FAIL ena_hold_byte[%0d]: got %h want %h", c, out_byte, b); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ena_hold_valid[%0d]: got %b want 1", c, out_valid); end
            n_checks++; if (fifo_count !== fc) begin n_fail++; $display("FAIL ena_hold_count[%0d]: got %0d want %0d", c, fifo_count, fc); end
        end
        n_checks++; if (got_q.size() != nr) begin n_fail++; $display("FAIL ena_no_handshake: got %0d bytes want %0d", got_q.size(), nr); end
        ena      = 1'b1;
        in_valid = 1'b0;
        run_stream(0, 200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL ena_timeout: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ena_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL ena_stable: got %0d changes want 0", stab_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        test_reset();
        test_single();
        test_backpressure();
        test_full();
        test_simultaneous();
        test_ena();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
